// File: rtl/gate_truth_checker.sv
// Drives a 2-input gate through vectors 00,01,10,11, samples its output after a settle time
// and scores it against an expected truth table. Define GATE_CHECK_LOOP_EN for continuous looping.
module gate_truth_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] expect_tt,
    input  logic       gate_y,
`ifdef GATE_CHECK_LOOP_EN
    input  logic       loop_en,
`endif
    output logic       drive_a,
    output logic       drive_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] pass_count
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);

    if (SETTLE == 0 || SETTLE > 255) begin : g_bad_settle
        $error("gate_truth_checker: SETTLE must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       tt_q, tt_d;

    logic             drive_a_d, drive_b_d, busy_d, done_d, pass_d;
    logic [3:0]       fail_mask_d;
    logic [2:0]       pass_count_d;
    logic             match_c;
    logic             loop_c;

`ifdef GATE_CHECK_LOOP_EN
    assign loop_c = loop_en;
`else
    assign loop_c = 1'b0;
`endif

    // Next-state and next-output logic; each vector occupies SETTLE+1 cycles,
    // the last of which ends on the sample edge.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        tt_d         = tt_q;
        fail_mask_d  = fail_mask;
        pass_count_d = pass_count;
        pass_d       = pass;
        done_d       = 1'b0;
        match_c      = (gate_y == tt_q[idx_q]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    tt_d         = expect_tt;
                    idx_d        = 2'd0;
                    cnt_d        = CNT_W'(SETTLE);
                    fail_mask_d  = 4'b0000;
                    pass_count_d = 3'd0;
                    pass_d       = 1'b0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (!match_c) begin
                        fail_mask_d[idx_q] = 1'b1;
                    end
                    // Vector 0 opens a new iteration, so the match count restarts there.
                    pass_count_d = ((idx_q == 2'd0) ? 3'd0 : pass_count) + 3'(match_c);
                    cnt_d        = CNT_W'(SETTLE);
                    idx_d        = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        done_d = 1'b1;
                        pass_d = (fail_mask_d == 4'b0000);
                        if (!loop_c) begin
                            state_d = FIN;
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d == RUN);
        drive_a_d = busy_d & idx_d[1];
        drive_b_d = busy_d & idx_d[0];
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            tt_q       <= 4'b0000;
            drive_a    <= 1'b0;
            drive_b    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= 4'b0000;
            pass_count <= 3'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tt_q       <= tt_d;
            drive_a    <= drive_a_d;
            drive_b    <= drive_b_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            fail_mask  <= fail_mask_d;
            pass_count <= pass_count_d;
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: one DUT with SETTLE=2 and one with SETTLE=1,
// each closing the loop through a modelled gate.
module tb_gate_truth_checker;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [3:0] expect_tt;
    logic       gate_y;
    logic       drive_a, drive_b, busy, done, pass;
    logic [3:0] fail_mask;
    logic [2:0] pass_count;

    logic       start1;
    logic [3:0] expect_tt1;
    logic       gate_y1;
    logic       drive_a1, drive_b1, busy1, done1, pass1;
    logic [3:0] fail_mask1;
    logic [2:0] pass_count1;

    logic       force_one;
    logic       corrupt_v2;
`ifdef GATE_CHECK_LOOP_EN
    logic       loop_en;
`endif

    int total;
    int bad;

    // AND gate, optionally stuck at 1 or inverted on vector 10.
    assign gate_y  = force_one | ((drive_a & drive_b) ^ (corrupt_v2 & drive_a & ~drive_b));
    assign gate_y1 = drive_a1 & drive_b1;

    gate_truth_checker #(.SETTLE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .expect_tt  (expect_tt),
        .gate_y     (gate_y),
`ifdef GATE_CHECK_LOOP_EN
        .loop_en    (loop_en),
`endif
        .drive_a    (drive_a),
        .drive_b    (drive_b),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_mask  (fail_mask),
        .pass_count (pass_count)
    );

    gate_truth_checker #(.SETTLE(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .expect_tt  (expect_tt1),
        .gate_y     (gate_y1),
`ifdef GATE_CHECK_LOOP_EN
        .loop_en    (1'b0),
`endif
        .drive_a    (drive_a1),
        .drive_b    (drive_b1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .fail_mask  (fail_mask1),
        .pass_count (pass_count1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({drive_a, drive_b, busy, done, pass, fail_mask, pass_count} !== 12'd0) begin
            bad++;
            $display("FAIL reset_dut2: got %b want 0", {drive_a, drive_b, busy, done, pass, fail_mask, pass_count});
        end
        total++;
        if ({drive_a1, drive_b1, busy1, done1, pass1, fail_mask1, pass_count1} !== 12'd0) begin
            bad++;
            $display("FAIL reset_dut1: got %b want 0", {drive_a1, drive_b1, busy1, done1, pass1, fail_mask1, pass_count1});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_and_pass();
        logic [1:0] k;
        int         seq_bad;
        expect_tt = 4'b1000;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        seq_bad   = 0;
        for (int c = 0; c < 12; c++) begin
            k = 2'(c / 3);
            if ({busy, done, drive_a, drive_b} !== {2'b10, k}) begin
                seq_bad++;
                $display("FAIL and_seq c=%0d: got busy/done/a/b=%b want %b", c, {busy, done, drive_a, drive_b}, {2'b10, k});
            end
            tick();
        end
        total++;
        if (seq_bad != 0) bad++;
        total++;
        if ({busy, done, drive_a, drive_b} !== 4'b0100) begin
            bad++;
            $display("FAIL and_fin: got busy/done/a/b=%b want 0100", {busy, done, drive_a, drive_b});
        end
        total++;
        if ({pass, fail_mask, pass_count} !== {1'b1, 4'b0000, 3'd4}) begin
            bad++;
            $display("FAIL and_result: got pass/mask/cnt=%b/%b/%0d want 1/0000/4", pass, fail_mask, pass_count);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL and_done_pulse: got done=%b want 0", done);
        end
    endtask

    task automatic test_or_table();
        expect_tt = 4'b1110;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        total++;
        if ({done, pass, fail_mask, pass_count} !== {1'b1, 1'b0, 4'b0110, 3'd2}) begin
            bad++;
            $display("FAIL or_result: got done/pass/mask/cnt=%b/%b/%b/%0d want 1/0/0110/2", done, pass, fail_mask, pass_count);
        end
    endtask

    task automatic test_start_ignored();
        int done_cnt;
        int done_at;
        force_one = 1'b1;
        expect_tt = 4'b1000;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        expect_tt = 4'b0111;
        done_cnt  = 0;
        done_at   = -1;
        for (int c = 1; c <= 20; c++) begin
            start = (c == 5 || c == 13);
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
        end
        start = 1'b0;
        total++;
        if (done_cnt != 1 || done_at != 12) begin
            bad++;
            $display("FAIL stuck1_done: got count=%0d at=%0d want 1 at 12", done_cnt, done_at);
        end
        total++;
        if ({busy, pass, fail_mask, pass_count} !== {1'b0, 1'b0, 4'b0111, 3'd1}) begin
            bad++;
            $display("FAIL stuck1_result: got busy/pass/mask/cnt=%b/%b/%b/%0d want 0/0/0111/1", busy, pass, fail_mask, pass_count);
        end
        force_one = 1'b0;
    endtask

    task automatic test_reset_midrun();
        expect_tt = 4'b1000;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        total++;
        if ({busy, pass_count} !== {1'b1, 3'd2}) begin
            bad++;
            $display("FAIL midrun_partial: got busy/cnt=%b/%0d want 1/2", busy, pass_count);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if ({drive_a, drive_b, busy, done, pass, fail_mask, pass_count} !== 12'd0) begin
            bad++;
            $display("FAIL midrun_reset: got %b want 0", {drive_a, drive_b, busy, done, pass, fail_mask, pass_count});
        end
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 11; c++) tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL midrun_early_done: got done=%b want 0", done);
        end
        tick();
        total++;
        if ({done, pass, fail_mask, pass_count} !== {1'b1, 1'b1, 4'b0000, 3'd4}) begin
            bad++;
            $display("FAIL midrun_rerun: got done/pass/mask/cnt=%b/%b/%b/%0d want 1/1/0000/4", done, pass, fail_mask, pass_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] k;
        int         seq_bad;
        expect_tt1 = 4'b1000;
        start1     = 1'b1;
        tick();
        start1     = 1'b0;
        seq_bad    = 0;
        for (int c = 0; c < 8; c++) begin
            k = 2'(c / 2);
            if ({busy1, done1, drive_a1, drive_b1} !== {2'b10, k}) begin
                seq_bad++;
                $display("FAIL b2b_seq c=%0d: got busy/done/a/b=%b want %b", c, {busy1, done1, drive_a1, drive_b1}, {2'b10, k});
            end
            tick();
        end
        total++;
        if (seq_bad != 0) bad++;
        total++;
        if ({busy1, done1, pass1, fail_mask1, pass_count1} !== {2'b01, 1'b1, 4'b0000, 3'd4}) begin
            bad++;
            $display("FAIL b2b_first: got busy/done/pass/mask/cnt=%b/%b/%b/%b/%0d want 0/1/1/0000/4", busy1, done1, pass1, fail_mask1, pass_count1);
        end
        expect_tt1 = 4'b0110;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        total++;
        if ({busy1, done1} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_accept: got busy/done=%b want 10", {busy1, done1});
        end
        seq_bad = 0;
        for (int c = 1; c < 8; c++) begin
            tick();
            if (done1 !== 1'b0) seq_bad++;
        end
        total++;
        if (seq_bad != 0) begin
            bad++;
            $display("FAIL b2b_early_done: got %0d early pulses want 0", seq_bad);
        end
        tick();
        total++;
        if ({done1, pass1, fail_mask1, pass_count1} !== {1'b1, 1'b0, 4'b1110, 3'd1}) begin
            bad++;
            $display("FAIL b2b_second: got done/pass/mask/cnt=%b/%b/%b/%0d want 1/0/1110/1", done1, pass1, fail_mask1, pass_count1);
        end
    endtask

`ifdef GATE_CHECK_LOOP_EN
    task automatic test_loop();
        int busy_bad;
        int done_bad;
        expect_tt  = 4'b1000;
        loop_en    = 1'b1;
        corrupt_v2 = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        busy_bad   = 0;
        done_bad   = 0;
        for (int c = 1; c <= 36; c++) begin
            if (c == 10) corrupt_v2 = 1'b0;
            if (c == 25) loop_en = 1'b0;
            tick();
            if (c < 36 && busy !== 1'b1) busy_bad++;
            if (done !== (c == 12 || c == 24 || c == 36)) done_bad++;
            if (c == 12) begin
                total++;
                if ({pass, fail_mask, pass_count} !== {1'b0, 4'b0100, 3'd3}) begin
                    bad++;
                    $display("FAIL loop_iter1: got pass/mask/cnt=%b/%b/%0d want 0/0100/3", pass, fail_mask, pass_count);
                end
            end
            if (c == 24) begin
                total++;
                if ({pass, fail_mask, pass_count} !== {1'b0, 4'b0100, 3'd4}) begin
                    bad++;
                    $display("FAIL loop_iter2: got pass/mask/cnt=%b/%b/%0d want 0/0100/4", pass, fail_mask, pass_count);
                end
            end
        end
        total++;
        if (busy_bad != 0 || done_bad != 0) begin
            bad++;
            $display("FAIL loop_timing: got busy_errs=%0d done_errs=%0d want 0/0", busy_bad, done_bad);
        end
        total++;
        if ({busy, fail_mask, pass_count} !== {1'b0, 4'b0100, 3'd4}) begin
            bad++;
            $display("FAIL loop_exit: got busy/mask/cnt=%b/%b/%0d want 0/0100/4", busy, fail_mask, pass_count);
        end
        tick();
    endtask
`endif

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start1     = 1'b0;
        expect_tt  = 4'b0000;
        expect_tt1 = 4'b0000;
        force_one  = 1'b0;
        corrupt_v2 = 1'b0;
`ifdef GATE_CHECK_LOOP_EN
        loop_en    = 1'b0;
`endif
        total      = 0;
        bad        = 0;

        test_reset();
        test_and_pass();
        tick();
        test_or_table();
        tick();
        tick();
        test_start_ignored();
        test_reset_midrun();
        tick();
        tick();
        test_back_to_back();
`ifdef GATE_CHECK_LOOP_EN
        tick();
        tick();
        test_loop();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
